// File: rtl/video_pkg.sv
// Shared definitions for the video timing generator.
//   h_state_t / v_state_t : horizontal and vertical phase encodings
//   axis_phase_t          : generic phase encoding used inside timing_axis
//   VID720_*              : default 1280x720p60 timing constants
//   pol_level()           : maps an "asserted" flag onto a sync polarity
package video_pkg;

    typedef enum logic [1:0] {
        H_ACT  = 2'd0,
        H_FP   = 2'd1,
        H_SYNC = 2'd2,
        H_BP   = 2'd3
    } h_state_t;

    typedef enum logic [1:0] {
        V_ACT  = 2'd0,
        V_FP   = 2'd1,
        V_SYNC = 2'd2,
        V_BP   = 2'd3
    } v_state_t;

    // Both axes share this ordering, so a phase value casts directly
    // onto h_state_t or v_state_t.
    typedef enum logic [1:0] {
        PH_ACT  = 2'd0,
        PH_FP   = 2'd1,
        PH_SYNC = 2'd2,
        PH_BP   = 2'd3
    } axis_phase_t;

    localparam int  VID720_H_ACTIVE = 1280;
    localparam int  VID720_H_FP     = 110;
    localparam int  VID720_H_SYNC   = 40;
    localparam int  VID720_H_BP     = 220;
    localparam int  VID720_V_ACTIVE = 720;
    localparam int  VID720_V_FP     = 5;
    localparam int  VID720_V_SYNC   = 5;
    localparam int  VID720_V_BP     = 20;
    localparam bit  VID720_HS_POL   = 1'b1;
    localparam bit  VID720_VS_POL   = 1'b1;

    localparam int  H_CNT_W = 12;
    localparam int  V_CNT_W = 11;

    function automatic logic pol_level(input logic asserted, input logic pol);
        return asserted ? pol : ~pol;
    endfunction

endpackage

// File: rtl/timing_axis.sv
// Generic 4-phase counter (ACT -> FP -> SYNC -> BP -> ACT).
// Each phase lasts exactly LENn advance strobes, tracked by a down-counter
// that loads LENn-1 on phase entry and leaves the phase when it reaches 0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   advance    : step the axis by one unit (pixel or line)
//   phase      : current phase (axis_phase_t encoding)
//   cnt        : remaining units in the current phase minus one
//   at_start   : current position is the first unit of the ACT phase
module timing_axis
    import video_pkg::*;
#(
    parameter int W    = 12,
    parameter int LEN0 = 1,
    parameter int LEN1 = 1,
    parameter int LEN2 = 1,
    parameter int LEN3 = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         advance,
    output logic [1:0]   phase,
    output logic [W-1:0] cnt,
    output logic         at_start
);

    axis_phase_t  phase_reg, phase_next;
    logic [W-1:0] cnt_reg, cnt_next;

    function automatic logic [W-1:0] last_idx(input axis_phase_t p);
        case (p)
            PH_ACT:  return W'(LEN0 - 1);
            PH_FP:   return W'(LEN1 - 1);
            PH_SYNC: return W'(LEN2 - 1);
            default: return W'(LEN3 - 1);
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= PH_ACT;
            cnt_reg   <= W'(LEN0 - 1);
        end else begin
            phase_reg <= phase_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        phase_next = phase_reg;
        cnt_next   = cnt_reg;
        if (advance) begin
            if (cnt_reg == '0) begin
                // Two-bit encoding wraps BP back to ACT.
                phase_next = axis_phase_t'(2'(phase_reg + 2'd1));
                cnt_next   = last_idx(phase_next);
            end else begin
                cnt_next = cnt_reg - 1'b1;
            end
        end
    end

    assign phase    = phase_reg;
    assign cnt      = cnt_reg;
    assign at_start = (phase_reg == PH_ACT) && (cnt_reg == W'(LEN0 - 1));

endmodule

// File: rtl/video_timing_gen.sv
// Video timing generator for a TMDS transmitter.
// Two timing_axis instances hold the position of the *next* pixel to emit;
// every enabled clock decodes that position into the registered outputs and
// steps it forward. This gives pixel (0,0) on the first enabled edge after
// reset and keeps all outputs aligned on the same register stage.
// Ports:
//   clk, rst_n        : pixel clock, asynchronous active-low reset
//   en                : advance enable; low freezes state and outputs
//   vde               : video data enable
//   hsync, vsync      : polarity-applied syncs
//   cd                : {vsync, hsync} for the blue-channel encoder
//   x, y              : active pixel coordinate (valid while vde=1)
//   line_start        : first ACT cycle of every line (incl. blanking lines)
//   frame_start       : output cycle of pixel (0,0)
module video_timing_gen #(
    parameter int H_ACTIVE = video_pkg::VID720_H_ACTIVE,
    parameter int H_FP     = video_pkg::VID720_H_FP,
    parameter int H_SYNC   = video_pkg::VID720_H_SYNC,
    parameter int H_BP     = video_pkg::VID720_H_BP,
    parameter int V_ACTIVE = video_pkg::VID720_V_ACTIVE,
    parameter int V_FP     = video_pkg::VID720_V_FP,
    parameter int V_SYNC   = video_pkg::VID720_V_SYNC,
    parameter int V_BP     = video_pkg::VID720_V_BP,
    parameter bit HS_POL   = video_pkg::VID720_HS_POL,
    parameter bit VS_POL   = video_pkg::VID720_VS_POL
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        vde,
    output logic        hsync,
    output logic        vsync,
    output logic [1:0]  cd,
    output logic [11:0] x,
    output logic [10:0] y,
    output logic        line_start,
    output logic        frame_start
);

    import video_pkg::h_state_t;
    import video_pkg::v_state_t;
    import video_pkg::pol_level;

    localparam int HW = video_pkg::H_CNT_W;
    localparam int VW = video_pkg::V_CNT_W;

    logic [1:0]    h_phase, v_phase;
    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_start, v_start;
    logic          h_wrap;
    h_state_t      h_state;
    v_state_t      v_state;
    logic          pos_act;
    logic [11:0]   x_pos;
    logic [10:0]   y_pos;

    logic          vde_reg, hsync_reg, vsync_reg;
    logic          line_start_reg, frame_start_reg;
    logic [11:0]   x_reg;
    logic [10:0]   y_reg;

    timing_axis #(
        .W(HW), .LEN0(H_ACTIVE), .LEN1(H_FP), .LEN2(H_SYNC), .LEN3(H_BP)
    ) u_h_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (en),
        .phase    (h_phase),
        .cnt      (h_cnt),
        .at_start (h_start)
    );

    // The vertical axis steps once per line, on the clock that leaves H_BP.
    timing_axis #(
        .W(VW), .LEN0(V_ACTIVE), .LEN1(V_FP), .LEN2(V_SYNC), .LEN3(V_BP)
    ) u_v_axis (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (en && h_wrap),
        .phase    (v_phase),
        .cnt      (v_cnt),
        .at_start (v_start)
    );

    assign h_state = h_state_t'(h_phase);
    assign v_state = v_state_t'(v_phase);
    assign h_wrap  = (h_state == video_pkg::H_BP) && (h_cnt == '0);
    assign pos_act = (h_state == video_pkg::H_ACT) && (v_state == video_pkg::V_ACT);

    // ACT counters run down from ACTIVE-1, so the coordinate is the complement.
    assign x_pos = 12'(H_ACTIVE - 1) - h_cnt;
    assign y_pos = 11'(V_ACTIVE - 1) - v_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vde_reg         <= 1'b0;
            hsync_reg       <= ~HS_POL;
            vsync_reg       <= ~VS_POL;
            line_start_reg  <= 1'b0;
            frame_start_reg <= 1'b0;
            x_reg           <= '0;
            y_reg           <= '0;
        end else if (en) begin
            vde_reg         <= pos_act;
            hsync_reg       <= pol_level(h_state == video_pkg::H_SYNC, HS_POL);
            vsync_reg       <= pol_level(v_state == video_pkg::V_SYNC, VS_POL);
            line_start_reg  <= h_start;
            frame_start_reg <= h_start && v_start;
            if (pos_act) begin
                x_reg <= x_pos;
                y_reg <= y_pos;
            end
        end
    end

    assign vde         = vde_reg;
    assign hsync       = hsync_reg;
    assign vsync       = vsync_reg;
    assign cd          = {vsync_reg, hsync_reg};
    assign x           = x_reg;
    assign y           = y_reg;
    assign line_start  = line_start_reg;
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen with an 8/2/3/3 x 4/1/2/1 raster.
// Two instances run in lockstep: one with active-high syncs, one with
// active-low syncs. The stimulus process pushes the expected outputs for
// each clock; a monitor pops and compares just after every clock edge.
module tb_video_timing_gen;

    localparam int HT = 16;   // 8 + 2 + 3 + 3
    localparam int VT = 8;    // 4 + 1 + 2 + 1

    typedef struct packed {
        logic        vde;
        logic        hs;
        logic        vs;
        logic [1:0]  cd;
        logic [11:0] x;
        logic [10:0] y;
        logic        ls;
        logic        fs;
    } exp_t;

    typedef struct packed {
        exp_t p1;   // HS_POL=VS_POL=1 instance
        exp_t p0;   // HS_POL=VS_POL=0 instance
    } pair_t;

    localparam exp_t RST1 = '{vde:1'b0, hs:1'b0, vs:1'b0, cd:2'b00, x:12'd0, y:11'd0, ls:1'b0, fs:1'b0};
    localparam exp_t RST0 = '{vde:1'b0, hs:1'b1, vs:1'b1, cd:2'b11, x:12'd0, y:11'd0, ls:1'b0, fs:1'b0};

    logic        clk, rst_n, en;
    logic        vde1, hs1, vs1, ls1, fs1;
    logic [1:0]  cd1;
    logic [11:0] x1;
    logic [10:0] y1;
    logic        vde0, hs0, vs0, ls0, fs0;
    logic [1:0]  cd0;
    logic [11:0] x0;
    logic [10:0] y0;

    int total = 0;
    int bad   = 0;

    pair_t sb[$];
    pair_t m_out;
    int    m_hc, m_vl;

    logic  meas_on = 1'b0;
    int    mcyc = 0, vde_cnt = 0, vs_cnt = 0, vs_first = 0, fs_first = 0, fs_second = 0;
    int    txn = 0;
    pair_t mon_e;
    exp_t  mon_a1, mon_a0;

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_pos (
        .clk(clk), .rst_n(rst_n), .en(en),
        .vde(vde1), .hsync(hs1), .vsync(vs1), .cd(cd1),
        .x(x1), .y(y1), .line_start(ls1), .frame_start(fs1)
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_neg (
        .clk(clk), .rst_n(rst_n), .en(en),
        .vde(vde0), .hsync(hs0), .vsync(vs0), .cd(cd0),
        .x(x0), .y(y0), .line_start(ls0), .frame_start(fs0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want test end");
        $fatal(1, "watchdog expired");
    end

    function automatic string fmt(input exp_t e);
        return $sformatf("vde=%b hs=%b vs=%b cd=%b x=%0d y=%0d ls=%b fs=%b",
                         e.vde, e.hs, e.vs, e.cd, e.x, e.y, e.ls, e.fs);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end else begin
            $display("check %s: 0x%0h ok", name, act);
        end
    endtask

    function automatic exp_t act1();
        return {vde1, hs1, vs1, cd1, x1, y1, ls1, fs1};
    endfunction

    function automatic exp_t act0();
        return {vde0, hs0, vs0, cd0, x0, y0, ls0, fs0};
    endfunction

    task automatic model_reset();
        m_hc     = 0;
        m_vl     = 0;
        m_out.p1 = RST1;
        m_out.p0 = RST0;
    endtask

    // Drive en for the next clock edge and push what that edge must produce.
    task automatic step(input logic v);
        logic act, hsa, vsa;
        @(negedge clk);
        en = v;
        if (v) begin
            act = (m_hc < 8) && (m_vl < 4);
            hsa = (m_hc >= 10) && (m_hc <= 12);
            vsa = (m_vl == 5) || (m_vl == 6);
            m_out.p1.vde = act;
            m_out.p1.hs  = hsa;
            m_out.p1.vs  = vsa;
            m_out.p1.cd  = {vsa, hsa};
            m_out.p1.ls  = (m_hc == 0);
            m_out.p1.fs  = (m_hc == 0) && (m_vl == 0);
            if (act) begin
                m_out.p1.x = 12'(m_hc);
                m_out.p1.y = 11'(m_vl);
            end
            m_out.p0    = m_out.p1;
            m_out.p0.hs = ~hsa;
            m_out.p0.vs = ~vsa;
            m_out.p0.cd = {~vsa, ~hsa};
            m_hc++;
            if (m_hc == HT) begin
                m_hc = 0;
                m_vl = (m_vl + 1) % VT;
            end
        end
        sb.push_back(m_out);
    endtask

    // Monitor: one transaction per clock edge that has a pushed expectation.
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e  = sb.pop_front();
            mon_a1 = act1();
            mon_a0 = act0();
            txn++;
            total += 2;
            if (mon_a1 !== mon_e.p1) begin
                bad++;
                $display("FAIL txn%0d_pos: got %s want %s", txn, fmt(mon_a1), fmt(mon_e.p1));
            end
            if (mon_a0 !== mon_e.p0) begin
                bad++;
                $display("FAIL txn%0d_neg: got %s want %s", txn, fmt(mon_a0), fmt(mon_e.p0));
            end
            $display("txn %0d en=%b %s", txn, en, fmt(mon_a1));
            if (meas_on) begin
                mcyc++;
                if (mcyc <= 128) begin
                    vde_cnt += int'(vde1);
                    vs_cnt  += int'(vs1);
                    if (vs1 && vs_first == 0) vs_first = mcyc;
                end
                if (fs1) begin
                    if (fs_first == 0) fs_first = mcyc;
                    else if (fs_second == 0) fs_second = mcyc;
                end
            end
        end
    end

    initial begin
        bit found;
        rst_n = 1'b0;
        en    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("reset_pos", 32'(act1()), 32'(RST1));
        chk("reset_neg", 32'(act0()), 32'(RST0));

        // Release, then the first enabled edge must emit pixel (0,0).
        @(negedge clk);
        rst_n   = 1'b1;
        meas_on = 1'b1;
        step(1'b1);
        @(posedge clk);
        #2;
        chk("first_vde", 32'(vde1), 32'd1);
        chk("first_x",   32'(x1),   32'd0);
        chk("first_y",   32'(y1),   32'd0);
        chk("first_fs",  32'(fs1),  32'd1);
        chk("first_ls",  32'(ls1),  32'd1);

        repeat (128) step(1'b1);
        @(posedge clk);
        #2;
        meas_on = 1'b0;
        chk("frame_vde_cycles",  32'(vde_cnt),             32'd32);
        chk("frame_vsync_cycles", 32'(vs_cnt),             32'd32);
        chk("vsync_first_cycle", 32'(vs_first),            32'd81);
        chk("frame_period",      32'(fs_second - fs_first), 32'd128);

        // Finish frame 2; the next edge is pixel (0,0) again.
        repeat (127) step(1'b1);

        // Hold at x=3, y=2 for five cycles.
        repeat (36) step(1'b1);
        repeat (5) step(1'b0);
        @(posedge clk);
        #2;
        chk("hold_x",   32'(x1),   32'd3);
        chk("hold_y",   32'(y1),   32'd2);
        chk("hold_vde", 32'(vde1), 32'd1);
        chk("hold_ls",  32'(ls1),  32'd0);
        step(1'b1);
        @(posedge clk);
        #2;
        chk("resume_x", 32'(x1), 32'd4);

        // Advance until the upcoming edge emits the middle H_SYNC pixel.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step(1'b1);
            if (m_hc == 12) found = 1'b1;
        end
        chk("sync_search", 32'(found), 32'd1);
        @(posedge clk);
        #2;
        chk("pre_reset_hsync_pos", 32'(hs1), 32'd1);
        chk("pre_reset_hsync_neg", 32'(hs0), 32'd0);
        #1;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("async_reset_pos", 32'(act1()), 32'(RST1));
        chk("async_reset_neg", 32'(act0()), 32'(RST0));
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1);
        @(posedge clk);
        #2;
        chk("rerun_vde", 32'(vde1), 32'd1);
        chk("rerun_xy",  32'({x1, y1}), 32'd0);
        chk("rerun_fs",  32'(fs1), 32'd1);
        chk("rerun_ls",  32'(ls1), 32'd1);
        repeat (20) step(1'b1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #3;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 1280, meaning active pixels per line.
REQ-002 Parameter H_FP / H_SYNC / H_BP, default 110 / 40 / 220, meaning horizontal front porch, sync and back porch widths in clocks.
REQ-003 Parameter V_ACTIVE, default 720, meaning active lines per frame.
REQ-004 Parameter V_FP / V_SYNC / V_BP, default 5 / 5 / 20, meaning vertical front porch, sync and back porch widths in lines.
REQ-005 Parameter HS_POL / VS_POL, default 1 / 1, meaning sync level while asserted (1 = active-high).
REQ-006 Port clk, input, 1 bit: pixel clock, rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-008 Port en, input, 1 bit: advance enable; when low, all state and outputs hold.
REQ-009 Port vde, output, 1 bit: video data enable, feeding the TMDS encoder's VDE input.
REQ-010 Port hsync / vsync, outputs, 1 bit each: polarity-applied syncs.
REQ-011 Port cd, output, 2 bits: {vsync, hsync}, feeding the blue-channel encoder's CD input.
REQ-012 Port x / y, outputs, 12 / 11 bits: pixel coordinate of the current output cycle, meaningful only while vde=1.
REQ-013 Port line_start / frame_start, outputs, 1 bit each: single-cycle pulses.

Function
REQ-014 Horizontal FSM states: H_ACT, H_FP, H_SYNC, H_BP, held with a per-state down-counter; sequence H_ACT->H_FP->H_SYNC->H_BP->H_ACT.
REQ-015 Vertical FSM states: V_ACT, V_FP, V_SYNC, V_BP; a state advances only on the clock that leaves H_BP (end of line).
REQ-016 H_TOTAL = sum of the H parameters; V_TOTAL = sum of the V parameters; each state lasts exactly its parameter count.
REQ-017 All outputs are registered and consistent on the same clock (zero skew between vde, syncs, cd, x, y and the pulses).
REQ-018 vde=1 iff the H state is H_ACT and the V state is V_ACT.
REQ-019 hsync = HS_POL during H_SYNC, otherwise ~HS_POL; vsync = VS_POL for entire lines in V_SYNC, otherwise ~VS_POL.
REQ-020 x increments 0..H_ACTIVE-1 across active pixels; y increments 0..V_ACTIVE-1 across active lines; both hold during blanking.
REQ-021 line_start pulses on the first H_ACT cycle of every line, including blanking lines.
REQ-022 frame_start pulses on the output cycle of pixel (0,0) only.
REQ-023 Latency: the first rising edge with en=1 after reset release outputs pixel (0,0) with vde=1, line_start=1 and frame_start=1.
REQ-024 At the end of V_BP's last line (wrap), the next cycle is pixel (0,0) of the next frame with no gap cycle.
REQ-025 When en=0, all outputs hold their last value and no pulse repeats; when en returns to 1, the sequence resumes from the exact held position.
REQ-026 Parameters are elaborated constants; every parameter must be ≥1; counters are sized for ≤4095 horizontal and ≤2047 vertical totals.

Reset
REQ-027 While rst_n=0: H_ACT/V_ACT with counters at start, x=0, y=0, vde=0, line_start=0, frame_start=0, hsync=~HS_POL, vsync=~VS_POL, cd={~VS_POL,~HS_POL}.
REQ-028 A reset asserted mid-frame takes effect immediately (asynchronously); after release, behaviour is identical to REQ-023.

Structure
REQ-029 The state enums (h_state_t, v_state_t) and the 720p default timing constants live in the shared package video_pkg.
REQ-030 One sub-module, timing_axis, implements a generic 4-state phase counter with an advance input; it is instantiated twice, once for H and once for V, with V advanced by H's end-of-line strobe.

Verification
REQ-031 Use small parameters H=8/2/3/3 and V=4/1/2/1 unless stated; release reset with en=1 -> cycle 1: vde=1, x=0, y=0, frame_start=1, line_start=1.
REQ-032 Run one line -> vde high for 8 cycles (x=0..7), then 2 cycles of blanking with hsync inactive, 3 cycles of hsync=1, 3 cycles of back porch; next line y=1, line_start=1.
REQ-033 Run a full frame -> exactly 32 vde cycles; vsync=1 during lines 5-6 (16 clocks each); frame_start recurs after exactly 128 clocks.
REQ-034 Drop en for 5 cycles at x=3, y=2 -> outputs frozen for 5 cycles, no repeated pulses; resumes at x=4.
REQ-035 Assert rst_n=0 asynchronously mid-H_SYNC -> outputs reach reset values before the next clock edge; after release, REQ-031 behaviour.
REQ-036 Set HS_POL=0 and VS_POL=0 -> syncs idle high, low during sync; cd reflects the polarity-applied levels.
